bt_tx_arq: RTL
==============

# bt_tx_arq

Transmit-side ACL ARQ controller for the baseband link controller, clocked at 6 MHz. Each own TX slot it decides the payload to carry: new, retransmitted, zero-length continuation, or none (NULL/POLL). It also drives the outgoing SEQN. It consumes the ARQN/FLOW bits decoded from received headers, and releases entries of the ACL TX buffer once they are acknowledged or flushed. It sits between the RX header decoder and the packet encoder, opposite the receive-side ACK/SEQN filter.

## Interface
- FLUSH_W, 8: width of flush timeout (TX slots).
- RETX_W, 8: width of retransmission counter.

Ports:
- clk_6M  in  1  6 MHz clock.
- rstz  in  1  reset, asynchronous, active-low.
- conn_new  in  1  pulse: new connection established; reinitialises all state.
- tx_slot_p  in  1  pulse: decide payload for the upcoming own TX slot.
- rx_hdr_valid  in  1  pulse: addressed, HEC-good header decoded.
- rx_arqn  in  1  ARQN of that header; 1 = ACK.
- rx_flow  in  1  FLOW of that header; 0 = STOP.
- acl_req  in  1  ACL TX buffer holds a payload.
- flush_cmd  in  1  pulse: host flush of the current payload.
- flush_to  in  FLUSH_W  flush timeout in TX slots; 0 = infinite.
- hdr_load_p  out  1  pulse: sel/tx_seqn updated for the encoder.
- sel  out  2  00 none, 01 new, 10 retransmit, 11 zero-length continuation.
- tx_seqn  out  1  SEQN for the packet header.
- acl_pop  out  1  pulse: release head entry of the ACL TX buffer.
- retx_cnt  out  RETX_W  retransmissions of the current payload, saturating.

## Operation
- State machine states:
  - IDLE: nothing outstanding.
  - SENT: payload sent, awaiting a response.
  - NAKED: response was NAK or missing.
- Reset and conn_new (conn_new overrides every other input):
  - state IDLE, seqn_q 0, flow_q 1, retx_cnt 0, flush counter 0, flush latch 0, zl flag 0.
  - Outputs: sel 00, tx_seqn 0, hdr_load_p 0, acl_pop 0.
- rx_hdr_valid:
  - flow_q <= rx_flow.
  - In SENT with rx_arqn=1: go to IDLE, pulse acl_pop unless the zl flag is set, clear the zl flag.
  - In SENT with rx_arqn=0: go to NAKED.
  - In IDLE or NAKED: only flow_q is updated.
- tx_slot_p in IDLE:
  - If acl_req and flow_q: sel 01, toggle seqn_q (the first packet after a connection carries SEQN 1), retx_cnt 0, flush counter 0, go to SENT.
  - Otherwise: sel 00.
- tx_slot_p in SENT: no response arrived, so treat it as NAK and apply the NAKED rules in the same cycle.
- tx_slot_p in NAKED or SENT:
  - Flush taken (flush latch set, or flush_to != 0 and flush counter ≥ flush_to): pulse acl_pop, sel 11, toggle seqn_q, set zl flag, clear flush latch and counter, go to SENT.
  - Else if flow_q=0: sel 00, stay NAKED.
  - Else: sel 10, retx_cnt +1 (saturating at all-ones), flush counter +1 (saturating), go to SENT.
- flush_cmd is latched until consumed and is ignored in IDLE. A new flush_cmd arriving while the zl flag is set is dropped.
- tx_seqn = seqn_q. It changes only with hdr_load_p.

## Timing
- Decision latency: hdr_load_p pulses one clk_6M cycle after tx_slot_p, together with the new sel and tx_seqn. sel and tx_seqn then hold until the next hdr_load_p.
- An ACK-driven acl_pop pulses one cycle after rx_hdr_valid. A flush-driven acl_pop coincides with hdr_load_p.
- acl_pop is exactly one cycle wide. There is at most one pop per payload.
- Simultaneous rx_hdr_valid and tx_slot_p: the header is applied first, and the slot decision uses the resulting state and flow_q.
- A tx_slot_p arriving while the previous decision is still pending: the later pulse is dropped. One decision is made per accepted pulse.
- conn_new in the middle of an outstanding payload: no acl_pop is issued. The buffer owner discards the payload.

## Configuration
- BT_TXARQ_FLUSH_EN defined: flush_cmd, flush_to, the flush counter and sel 11 are operational.
- Undefined:
  - flush_cmd and flush_to are ignored, the counter and latch are removed.
  - sel is never 11, and a NAKed payload is retransmitted indefinitely.
  - The zl flag is constant 0.

## Test plan
- Reset, conn_new, acl_req=1, tx_slot_p → next cycle hdr_load_p=1, sel=01, tx_seqn=1. Then rx_hdr_valid with arqn=1 → acl_pop one cycle later. Next tx_slot_p → sel=01, tx_seqn=0.
- After a new send, rx_hdr_valid with arqn=0, then tx_slot_p three times → sel=10 each time, tx_seqn unchanged, retx_cnt=3, no acl_pop.
- Outstanding payload, no header received, tx_slot_p → sel=10 (missing response treated as NAK).
- rx_flow=0 while in NAKED, tx_slot_p → sel=00. Then rx_flow=1 header, tx_slot_p → sel=10.
- FLUSH_EN with flush_to=2, NAK persists → retransmits at slots 1–2, then slot 3 gives sel=11, acl_pop with hdr_load_p, and tx_seqn toggled. ACK of the continuation produces no second pop.
- rx_hdr_valid (arqn=1) and tx_slot_p in the same cycle with acl_req=1 → a single acl_pop, then sel=01 with tx_seqn toggled. Asserting conn_new mid-sequence → all outputs are back at their reset values next cycle.

Source files
------------

// File: rtl/bt_tx_arq.sv
// bt_tx_arq: transmit-side ACL ARQ controller (6 MHz baseband clock).
// Chooses the payload for each own TX slot (new, retransmit, zero-length
// continuation or none), drives SEQN and releases ACL TX buffer entries.
// Optional build macro BT_TXARQ_FLUSH_EN enables flush_cmd/flush_to,
// the flush counter/latch and sel=11 continuation packets.
// Ports:
//   clk_6M, rstz        clock, async active-low reset
//   conn_new            new connection, reinitialises everything
//   tx_slot_p           decide payload for the upcoming own TX slot
//   rx_hdr_valid/arqn/flow  decoded response header (ARQN 1=ACK, FLOW 0=STOP)
//   acl_req             ACL TX buffer holds a payload
//   flush_cmd, flush_to host flush / flush timeout in TX slots (0=infinite)
//   hdr_load_p, sel, tx_seqn  decision to the packet encoder
//   acl_pop             release head entry of ACL TX buffer
//   retx_cnt            saturating retransmission count of current payload
module bt_tx_arq #(
    parameter int FLUSH_W = 8,
    parameter int RETX_W  = 8
) (
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic               conn_new,
    input  logic               tx_slot_p,
    input  logic               rx_hdr_valid,
    input  logic               rx_arqn,
    input  logic               rx_flow,
    input  logic               acl_req,
    input  logic               flush_cmd,
    input  logic [FLUSH_W-1:0] flush_to,
    output logic               hdr_load_p,
    output logic [1:0]         sel,
    output logic               tx_seqn,
    output logic               acl_pop,
    output logic [RETX_W-1:0]  retx_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SENT  = 2'd1;
    localparam logic [1:0] S_NAKED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              seqn_q, seqn_d;
    logic              flow_q, flow_d;
    logic [RETX_W-1:0] retx_q, retx_d;
    logic [1:0]        sel_q, sel_d;
    logic              hdr_q, hdr_d;
    logic              pop_q, pop_d;
    logic              flush_take;

`ifdef BT_TXARQ_FLUSH_EN
    logic [FLUSH_W-1:0] fcnt_q, fcnt_d;
    logic               flat_q, flat_d;
    logic               zl_q, zl_d;
`else
    logic zl_q;
    assign zl_q = 1'b0;
    logic unused_flush;
    assign unused_flush = ^{flush_cmd, flush_to};
`endif

    always_comb begin
        state_d    = state_q;
        seqn_d     = seqn_q;
        flow_d     = flow_q;
        retx_d     = retx_q;
        sel_d      = sel_q;
        hdr_d      = 1'b0;
        pop_d      = 1'b0;
        flush_take = 1'b0;
`ifdef BT_TXARQ_FLUSH_EN
        fcnt_d = fcnt_q;
        flat_d = flat_q;
        zl_d   = zl_q;
`endif
        if (conn_new) begin
            state_d = S_IDLE;
            seqn_d  = 1'b0;
            flow_d  = 1'b1;
            retx_d  = '0;
            sel_d   = 2'b00;
`ifdef BT_TXARQ_FLUSH_EN
            fcnt_d = '0;
            flat_d = 1'b0;
            zl_d   = 1'b0;
`endif
        end else begin
            // Header is applied first; a same-cycle slot sees its result.
            if (rx_hdr_valid) begin
                flow_d = rx_flow;
                if (state_q == S_SENT) begin
                    if (rx_arqn) begin
                        state_d = S_IDLE;
                        // A zero-length continuation's payload was
                        // already released when it was flushed.
                        pop_d = ~zl_q;
`ifdef BT_TXARQ_FLUSH_EN
                        zl_d = 1'b0;
`endif
                    end else begin
                        state_d = S_NAKED;
                    end
                end
            end
`ifdef BT_TXARQ_FLUSH_EN
            if (flush_cmd && state_d != S_IDLE && !zl_d)
                flat_d = 1'b1;
`endif
            // A slot pulse while the last decision is still being
            // presented is dropped.
            if (tx_slot_p && !hdr_q) begin
                hdr_d = 1'b1;
                if (state_d == S_IDLE) begin
                    if (acl_req && flow_d) begin
                        sel_d   = 2'b01;
                        seqn_d  = ~seqn_q;
                        retx_d  = '0;
                        state_d = S_SENT;
`ifdef BT_TXARQ_FLUSH_EN
                        fcnt_d = '0;
`endif
                    end else begin
                        sel_d = 2'b00;
                    end
                end else begin
                    // SENT here means no response arrived: same as NAK.
`ifdef BT_TXARQ_FLUSH_EN
                    flush_take = !zl_d && (flat_d ||
                        (flush_to != '0 && fcnt_q >= flush_to));
`endif
                    if (flush_take) begin
                        pop_d   = 1'b1;
                        sel_d   = 2'b11;
                        seqn_d  = ~seqn_q;
                        state_d = S_SENT;
`ifdef BT_TXARQ_FLUSH_EN
                        zl_d   = 1'b1;
                        flat_d = 1'b0;
                        fcnt_d = '0;
`endif
                    end else if (!flow_d) begin
                        sel_d   = 2'b00;
                        state_d = S_NAKED;
                    end else begin
                        sel_d   = 2'b10;
                        state_d = S_SENT;
                        if (retx_q != '1)
                            retx_d = retx_q + RETX_W'(1);
`ifdef BT_TXARQ_FLUSH_EN
                        if (fcnt_q != '1)
                            fcnt_d = fcnt_q + FLUSH_W'(1);
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= S_IDLE;
            seqn_q  <= 1'b0;
            flow_q  <= 1'b1;
            retx_q  <= '0;
            sel_q   <= 2'b00;
            hdr_q   <= 1'b0;
            pop_q   <= 1'b0;
`ifdef BT_TXARQ_FLUSH_EN
            fcnt_q <= '0;
            flat_q <= 1'b0;
            zl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            seqn_q  <= seqn_d;
            flow_q  <= flow_d;
            retx_q  <= retx_d;
            sel_q   <= sel_d;
            hdr_q   <= hdr_d;
            pop_q   <= pop_d;
`ifdef BT_TXARQ_FLUSH_EN
            fcnt_q <= fcnt_d;
            flat_q <= flat_d;
            zl_q   <= zl_d;
`endif
        end
    end

    assign hdr_load_p = hdr_q;
    assign sel        = sel_q;
    assign tx_seqn    = seqn_q;
    assign acl_pop    = pop_q;
    assign retx_cnt   = retx_q;

endmodule
